id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall/load-use bubble insertion and a saturating bubble counter.
// Define ID_EX_LOAD_USE_DET_EN to build the load-use hazard detector; otherwise hazard_o is tied to 0.
module id_ex_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        WB_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        MemtoReg_i,
  input  logic        ALUSrc_i,
  input  logic        RegDst_i,
  input  logic [2:0]  ALU_op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        WB_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        MemtoReg_o,
  output logic        ALUSrc_o,
  output logic        RegDst_o,
  output logic [2:0]  ALU_op_o,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  output logic [31:0] imm_o,
  output logic [31:0] pc_plus4_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic        valid_o,
  output logic        hazard_o,
  output logic [15:0] bubble_cnt_o
);

  typedef struct packed {
    logic        wb;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        valid;
  } stage_t;

  // ALU_op 3'b111 marks a bubble so EX decodes it as a no-op class.
  localparam stage_t BubbleStage = '{
    wb:         1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu_op:     3'b111,
    rs_data:    32'd0,
    rt_data:    32'd0,
    imm:        32'd0,
    pc_plus4:   32'd0,
    rs:         5'd0,
    rt:         5'd0,
    rd:         5'd0,
    funct:      6'd0,
    valid:      1'b0
  };

  stage_t      stage_q, stage_d, stage_in;
  logic [15:0] cnt_q, cnt_d;
  logic        load_bubble;

  always_comb begin
    stage_in.wb         = WB_i;
    stage_in.mem_read   = MemRead_i;
    stage_in.mem_write  = MemWrite_i;
    stage_in.mem_to_reg = MemtoReg_i;
    stage_in.alu_src    = ALUSrc_i;
    stage_in.reg_dst    = RegDst_i;
    stage_in.alu_op     = ALU_op_i;
    stage_in.rs_data    = rs_data_i;
    stage_in.rt_data    = rt_data_i;
    stage_in.imm        = imm_i;
    stage_in.pc_plus4   = pc_plus4_i;
    stage_in.rs         = rs_i;
    stage_in.rt         = rt_i;
    stage_in.rd         = rd_i;
    stage_in.funct      = funct_i;
    stage_in.valid      = valid_i;
  end

`ifdef ID_EX_LOAD_USE_DET_EN
  // MemtoReg, not MemRead, identifies a load: stores also raise MemRead.
  // rt of the ID instruction is only a source for R-type (ALUSrc=0) or store data.
  assign hazard_o = stage_q.valid & stage_q.mem_to_reg & (stage_q.rt != 5'd0) & valid_i &
                    ((rs_i == stage_q.rt) | ((rt_i == stage_q.rt) & (~ALUSrc_i | MemWrite_i)));
`else
  assign hazard_o = 1'b0;
`endif

  always_comb begin
    stage_d     = stage_q;
    load_bubble = 1'b0;
    if (flush_i) begin
      load_bubble = 1'b1;
    end else if (stall_i) begin
      stage_d = stage_q;
    end else if (hazard_o) begin
      load_bubble = 1'b1;
    end else begin
      stage_d = stage_in;
    end
    if (load_bubble) begin
      stage_d = BubbleStage;
    end

    cnt_d = cnt_q;
    if (load_bubble && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= BubbleStage;
      cnt_q   <= 16'd0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign WB_o         = stage_q.wb;
  assign MemRead_o    = stage_q.mem_read;
  assign MemWrite_o   = stage_q.mem_write;
  assign MemtoReg_o   = stage_q.mem_to_reg;
  assign ALUSrc_o     = stage_q.alu_src;
  assign RegDst_o     = stage_q.reg_dst;
  assign ALU_op_o     = stage_q.alu_op;
  assign rs_data_o    = stage_q.rs_data;
  assign rt_data_o    = stage_q.rt_data;
  assign imm_o        = stage_q.imm;
  assign pc_plus4_o   = stage_q.pc_plus4;
  assign rs_o         = stage_q.rs;
  assign rt_o         = stage_q.rt;
  assign rd_o         = stage_q.rd;
  assign funct_o      = stage_q.funct;
  assign valid_o      = stage_q.valid;
  assign bubble_cnt_o = cnt_q;

endmodule
